multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  4  operation code.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 y_out  output  WIDTH  primary result (sum, shift, slt, product low half, quotient).
REQ-012 hi_out  output  WIDTH  product high half for mul, remainder for divu, 0 for all other ops.
REQ-013 branch_eval  output  1  (a == b) for the accepted operands.

Function
REQ-014 Op encoding: 0000 add, 0001 addi, 0010 sll, 0011 slt, 0100 sw, 0101 lw, 0110 mul (unsigned), 0111 divu; every other code yields y_out = 0 and hi_out = 0.
REQ-015 add, addi, sw and lw produce a + b modulo 2^WIDTH.
REQ-016 sll produces a << b when b < WIDTH, and 0 when b >= WIDTH.
REQ-017 slt produces 1 when signed(a) < signed(b), else 0, zero-extended to WIDTH.
REQ-018 mul produces the full 2*WIDTH unsigned product {hi_out, y_out} by iterative shift-add, one bit per cycle.
REQ-019 divu produces the quotient in y_out and the remainder in hi_out by restoring division, one bit per cycle.
REQ-020 divu with b == 0 produces y_out = all ones and hi_out = a, with no error flag.
REQ-021 FSM states are IDLE, BUSY and DONE.
REQ-022 From IDLE, in_valid & in_ready captures a, b and op, then moves to DONE for single-cycle ops or to BUSY for mul/divu.
REQ-023 BUSY lasts exactly WIDTH cycles, driven by an iteration counter, then moves to DONE.
REQ-024 Latency from the accept edge to out_valid high: 1 cycle for single-cycle ops and WIDTH+1 cycles for mul/divu.
REQ-025 in_ready = 1 only in IDLE; at most one operation is outstanding.
REQ-026 In DONE, out_valid = 1, and y_out, hi_out and branch_eval are held stable until out_ready.
REQ-027 DONE with out_ready moves to IDLE, so in_ready rises one cycle later; accepting in the same cycle as result hand-off is not supported.
REQ-028 Operand or op changes while BUSY or DONE have no effect.
REQ-029 Outputs are registered; y_out, hi_out and branch_eval are don't-care when out_valid = 0 but are driven to 0 by reset.

Reset
REQ-030 rst on any edge, including mid-BUSY or in DONE, forces IDLE and clears the counter and all datapath registers.
REQ-031 After reset: out_valid = 0, y_out = 0, hi_out = 0, branch_eval = 0, in_ready = 1 on the first cycle after rst deasserts.
REQ-032 An in_valid asserted in the same cycle as rst is not accepted.

Structure
REQ-033 Package alu_pkg holds the op encoding constants, the FSM state enum and the OP_W = 4 constant.
REQ-034 Sub-module iter_muldiv (parameter WIDTH) holds the shift-add/restoring datapath and iteration counter, with start/done handshake to the top-level FSM.
REQ-035 Single-cycle ops are computed combinationally in the top level and registered on accept.

Verification
REQ-036 WIDTH=32, add a=7, b=0xFFFFFFFF -> out_valid 1 cycle after accept, y_out=6, hi_out=0, branch_eval=0.
REQ-037 slt a=0xFFFFFFFE, b=1 -> y_out=1; sll a=1, b=31 -> y_out=0x80000000; sll a=1, b=32 -> y_out=0.
REQ-038 mul a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid after 33 cycles, hi_out=0xFFFFFFFE, y_out=0x00000001.
REQ-039 divu a=100, b=7 -> y_out=14, hi_out=2; divu a=5, b=0 -> y_out=0xFFFFFFFF, hi_out=5.
REQ-040 mul started, then rst at BUSY cycle 10 -> next cycle in IDLE, out_valid=0, all outputs 0; a new add completes correctly.
REQ-041 out_ready held 0 for 5 cycles in DONE -> y_out stable and in_ready=0 throughout; in_ready=1 the cycle after out_ready is asserted; repeat with WIDTH=8.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle ALU: operation width, the operation
// encoding, the control FSM state type and a helper that classifies an op as
// iterative (mul/divu) or single-cycle.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SW   = 4'b0100;
  localparam logic [OP_W-1:0] OP_LW   = 4'b0101;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_DIVU = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True for the ops that run through the shift-add / restoring engine.
  function automatic logic is_iterative(input logic [OP_W-1:0] op_code);
    return (op_code == OP_MUL) || (op_code == OP_DIVU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// -----------------------------------------------------------------------------
// iter_muldiv
// One-bit-per-cycle unsigned multiplier (shift-add) and restoring divider.
// A start pulse loads the operands; the engine then runs exactly WIDTH
// iterations. o_done is high during the last iteration cycle, and o_hi/o_lo
// carry the value that iteration produces, so the parent can capture the
// final result on the same edge that would have stored it here.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_start        load operands and begin (one cycle)
//   i_is_div       1 = divu, 0 = mul (sampled with i_start)
//   i_a, i_b       operands (sampled with i_start)
//   o_done         last iteration in progress
//   o_hi, o_lo     mul: product high/low half; divu: remainder/quotient
// -----------------------------------------------------------------------------
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opnd;   // multiplicand for mul, divisor for divu
  logic [WIDTH-1:0] r_hi;     // partial product high / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier bits / dividend-then-quotient bits

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // One iteration step for both engines.
  always_comb begin
    // mul: add multiplicand when the current multiplier bit is set, then
    // shift the {carry, hi, lo} chain right by one.
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    // divu: shift the next dividend bit into the remainder and try to subtract.
    // The remainder after a successful subtract is below the divisor, so the
    // modulo-2^WIDTH difference is exact even when w_shift[WIDTH] is set.
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opnd});
    w_diff  = w_shift[WIDTH-1:0] - r_opnd;
    if (r_is_div) begin
      if (w_ge) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done = r_busy && (r_cnt == LAST);
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;

  // Operand load, iteration state and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_opnd   <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
      r_cnt    <= {CNT_W{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= i_is_div ? i_a : i_b;
      r_opnd   <= i_is_div ? i_b : i_a;
    end else if (r_busy) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= {CNT_W{1'b0}};
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// Small ALU with a valid/ready request side and a valid/ready result side.
// add/addi/sw/lw/sll/slt finish one cycle after accept; mul and divu run in
// iter_muldiv for WIDTH cycles. One operation is outstanding at a time and
// the result is held until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   a, b, op              operands and operation code
//   out_valid / out_ready result handshake
//   y_out                 primary result
//   hi_out                mul high half, divu remainder, else 0
//   branch_eval           (a == b) of the accepted operands
// -----------------------------------------------------------------------------
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             branch_eval
);

  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi;
  logic             r_branch;

  logic             w_accept;
  logic             w_start;
  logic [WIDTH-1:0] w_y_single;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_start  = w_accept && is_iterative(op);

  // Single-cycle results; registered only when the request is accepted.
  always_comb begin
    w_y_single = {WIDTH{1'b0}};
    case (op)
      OP_ADD, OP_ADDI, OP_SW, OP_LW: w_y_single = a + b;
      OP_SLL: begin
        // Shift amounts of WIDTH or more clear the result.
        if (b < WIDTH_VAL) begin
          w_y_single = a << b[SHW-1:0];
        end else begin
          w_y_single = {WIDTH{1'b0}};
        end
      end
      OP_SLT:  w_y_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_y_single = {WIDTH{1'b0}};
    endcase
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_is_div (op == OP_DIVU),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_md_done),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= {WIDTH{1'b0}};
      r_hi        <= {WIDTH{1'b0}};
      r_branch    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_branch   <= (a == b);
            if (is_iterative(op)) begin
              r_state <= ST_BUSY;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_y         <= w_y_single;
              r_hi        <= {WIDTH{1'b0}};
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Capture the final iteration's value on the edge that completes it.
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_y         <= w_md_lo;
            r_hi        <= w_md_hi;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign y_out       = r_y;
  assign hi_out      = r_hi;
  assign branch_eval = r_branch;

endmodule
